// File: rtl/switch_debounce_sync.sv
// Slide-switch front end: a 2-FF synchroniser per channel feeding a counter-based
// debounce FSM. Produces registered clean levels and 1-cycle rise/fall pulses.
module switch_debounce_sync #(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic             I_P_CLK,
  input  logic             I_P_RST,
  input  logic [WIDTH-1:0] I_P_SW,
  output logic [WIDTH-1:0] O_P_SW_DB,
  output logic [WIDTH-1:0] O_P_RISE,
  output logic [WIDTH-1:0] O_P_FALL,
  output logic [WIDTH-1:0] O_P_LED_DB
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] S_LOW       = 2'd0;
  localparam logic [1:0] S_WAIT_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH      = 2'd2;
  localparam logic [1:0] S_WAIT_LOW  = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [1:0]       state_q [WIDTH];
  logic [1:0]       state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  always_comb begin
    sync1_d = I_P_SW;
    sync2_d = sync1_q;
    db_d    = db_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // The count includes the first differing sample, so acceptance occurs on
      // the STABLE_CYCLES-th consecutive synchronised cycle at the new level.
      case (state_q[i])
        S_LOW: begin
          if (sync2_q[i]) begin
            state_d[i] = S_WAIT_HIGH;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_HIGH;
            db_d[i]    = 1'b1;
            rise_d[i]  = 1'b1;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_WAIT_LOW;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        S_WAIT_LOW: begin
          if (sync2_q[i]) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_LOW;
            db_d[i]    = 1'b0;
            fall_d[i]  = 1'b1;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = S_LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge I_P_CLK) begin
    if (I_P_RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      state_q <= '{default: S_LOW};
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign O_P_SW_DB  = db_q;
  assign O_P_LED_DB = db_q;
  assign O_P_RISE   = rise_q;
  assign O_P_FALL   = fall_q;

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: directed scenarios plus random hold patterns,
// checked every cycle against a run-length reference model of the debounce rule.
module tb_switch_debounce_sync;

  localparam int unsigned W = 2;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic [W-1:0] db, rise, fall, led;

  int checks = 0;
  int errors = 0;

  // Reference model: inputs seen by the debouncer lag two edges; a level is
  // accepted once it has differed from the output for S consecutive edges.
  logic [W-1:0] hist [2];
  int           run  [W];
  logic [W-1:0] m_db, m_rise, m_fall;

  always #5 clk = ~clk;

  switch_debounce_sync #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .I_P_CLK   (clk),
    .I_P_RST   (rst),
    .I_P_SW    (sw),
    .O_P_SW_DB (db),
    .O_P_RISE  (rise),
    .O_P_FALL  (fall),
    .O_P_LED_DB(led)
  );

  task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic [W-1:0] v, input logic r);
    logic [W-1:0] seen;
    if (r) begin
      hist[0] = '0;
      hist[1] = '0;
      m_db    = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
    end else begin
      seen   = hist[1];
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (seen[i] != m_db[i]) begin
          run[i]++;
          if (run[i] == S) begin
            m_db[i] = seen[i];
            if (seen[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      hist[1] = hist[0];
      hist[0] = v;
    end
  endtask

  task automatic step(input logic [W-1:0] v, input logic r);
    sw  = v;
    rst = r;
    @(posedge clk);
    model_edge(v, r);
    #1;
    check_vec("db",   db,   m_db);
    check_vec("rise", rise, m_rise);
    check_vec("fall", fall, m_fall);
    check_vec("led",  led,  m_db);
  endtask

  initial begin
    int first;
    int first1;
    int n_rise;
    int n_pulse;
    logic [W-1:0] v;
    int hold;

    sw  = '1;
    rst = 1'b1;
    for (int i = 0; i < W; i++) run[i] = 0;

    // Reset held with switches high; afterwards the high level needs 6 edges.
    for (int k = 0; k < 3; k++) step(2'b11, 1'b1);
    check_vec("reset_db", db, 2'b00);
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      step(2'b11, 1'b0);
      if (first == 0 && db == 2'b11) first = k;
    end
    check_int("reset_release_latency", first, 6);
    for (int k = 0; k < 8; k++) step(2'b00, 1'b0);

    // Clean rising step on channel 0.
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      step(2'b01, 1'b0);
      if (first == 0 && rise[0]) first = k;
      if (k == 7) check_vec("clean_rise_cleared", rise, 2'b00);
    end
    check_int("clean_rise_latency", first, 6);
    check_vec("clean_db", db, 2'b01);

    // Short glitch on channel 1 must be rejected.
    n_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      step(2'b11, 1'b0);
      n_pulse += int'(rise[1]) + int'(fall[1]);
    end
    for (int k = 0; k < 10; k++) begin
      step(2'b01, 1'b0);
      n_pulse += int'(rise[1]) + int'(fall[1]);
    end
    check_int("glitch_pulses", n_pulse, 0);
    check_vec("glitch_db", db, 2'b01);

    // Bounce on channel 0, then a stable high level.
    for (int k = 0; k < 8; k++) step(2'b00, 1'b0);
    n_rise = 0;
    for (int k = 0; k < 20; k++) begin
      v = '0;
      v[0] = ((k / 2) % 2 == 0);
      step(v, 1'b0);
      n_rise += int'(rise[0]);
    end
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      step(2'b01, 1'b0);
      n_rise += int'(rise[0]);
      if (first == 0 && rise[0]) first = k;
    end
    check_int("bounce_rise_count", n_rise, 1);
    check_int("bounce_latency", first, 6);

    // Simultaneous fall on both channels.
    for (int k = 0; k < 10; k++) step(2'b11, 1'b0);
    check_vec("both_high", db, 2'b11);
    first  = 0;
    first1 = 0;
    for (int k = 1; k <= 8; k++) begin
      step(2'b00, 1'b0);
      if (first  == 0 && fall[0]) first  = k;
      if (first1 == 0 && fall[1]) first1 = k;
    end
    check_int("fall0_latency", first, 6);
    check_int("fall1_latency", first1, 6);
    check_vec("fall_led", led, 2'b00);

    // Reset while the counter is mid-way through a rise.
    for (int k = 0; k < 5; k++) step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    check_vec("midwait_reset_db", db, 2'b00);
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      step(2'b01, 1'b0);
      if (first == 0 && db[0]) first = k;
    end
    check_int("midwait_restart_latency", first, 6);

    // Random hold lengths around the acceptance threshold, rare resets.
    for (int seg = 0; seg < 120; seg++) begin
      v    = W'($urandom_range(0, (1 << W) - 1));
      hold = int'($urandom_range(1, 8));
      for (int k = 0; k < hold; k++) step(v, ($urandom_range(0, 60) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
